// File: rtl/debnc_pkg.sv
// rtl/debnc_pkg.sv - shared state encoding and constants for the switch debouncer
package debnc_pkg;

  typedef enum logic [1:0] {
    LO      = 2'd0,
    WAIT_HI = 2'd1,
    HI      = 2'd2,
    WAIT_LO = 2'd3
  } debnc_state_t;

  localparam int DEBNC_SYNC_STAGES = 2;

endpackage

// File: rtl/debnc_chan.sv
// rtl/debnc_chan.sv - one debounce channel: synchroniser, qualification FSM, strobes
// Optional hold/long-press counter built when DEBNC_LONGPRESS_EN is defined.
module debnc_chan
  import debnc_pkg::*;
#(
  parameter int STABLE_CNT = 100000,
  parameter int LONG_CNT   = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

  logic [DEBNC_SYNC_STAGES-1:0] sync_q, sync_d;
  debnc_state_t                 state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         db_q, db_d;
  logic                         rise_q, rise_d;
  logic                         fall_q, fall_d;
  logic                         s;

  assign sync_d = {sync_q[DEBNC_SYNC_STAGES-2:0], sw};
  assign s      = sync_q[DEBNC_SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HI;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = HI;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LO;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBNC_LONGPRESS_EN
  localparam int HW = (LONG_CNT > 2) ? $clog2(LONG_CNT) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          lp_done_q, lp_done_d;
  logic          lp_q, lp_d;

  // A bounce back from WAIT_LO to HI keeps the running hold count.
  always_comb begin
    hold_d    = hold_q;
    lp_done_d = lp_done_q;
    lp_d      = 1'b0;
    if (state_q == WAIT_HI && state_d == HI) begin
      hold_d    = '0;
      lp_done_d = 1'b0;
    end else if (state_q == HI) begin
      if (hold_q == HOLD_MAX) begin
        if (!lp_done_q) begin
          lp_d      = 1'b1;
          lp_done_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else if (state_q == WAIT_LO && state_d == LO) begin
      hold_d    = '0;
      lp_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      lp_done_q <= 1'b0;
      lp_q      <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      lp_done_q <= lp_done_d;
      lp_q      <= lp_d;
    end
  end

  assign long_press = lp_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debnc_multi.sv
// rtl/debnc_multi.sv - N-channel switch debouncer with rise/fall strobes
// Long-press strobes are built only when DEBNC_LONGPRESS_EN is defined.
module debnc_multi
  import debnc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 100000,
  parameter int LONG_CNT   = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debnc_chan #(
      .STABLE_CNT(STABLE_CNT),
      .LONG_CNT  (LONG_CNT)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw[i]),
      .db        (db[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_debnc_multi.sv
// tb/tb_debnc_multi.sv - directed bench for debnc_multi (N_CH=2, STABLE_CNT=4, LONG_CNT=8)
// Long-press expectations follow DEBNC_LONGPRESS_EN.
module tb_debnc_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw;
  logic [1:0] db, rise, fall, long_press;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #10 clk = ~clk;

  debnc_multi #(
    .N_CH      (2),
    .STABLE_CNT(4),
    .LONG_CNT  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .db        (db),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edges 1..n-1 hold the old level, edge n shows the new level and strobes,
  // edge n+1 confirms the strobe lasted one cycle.
  task automatic watch(input string tag, input int n, input logic [1:0] db_b,
                       input logic [1:0] db_a, input logic [1:0] rs,
                       input logic [1:0] fl, input bit tog);
    for (int i = 1; i <= n + 1; i++) begin
      tick();
      if (tog) sw[1] = ~sw[1];
      if (i < n) begin
        chk({tag, "_db_pre"}, db, db_b);
        chk({tag, "_rise_pre"}, rise, 2'b00);
        chk({tag, "_fall_pre"}, fall, 2'b00);
      end else if (i == n) begin
        chk({tag, "_db"}, db, db_a);
        chk({tag, "_rise"}, rise, rs);
        chk({tag, "_fall"}, fall, fl);
      end else begin
        chk({tag, "_db_post"}, db, db_a);
        chk({tag, "_rise_post"}, rise, 2'b00);
        chk({tag, "_fall_post"}, fall, 2'b00);
      end
    end
  endtask

  initial begin
    logic [4:0] pat;
    logic [1:0] lp_exp;

    rst_n = 1'b0;
    sw    = 2'b11;
    repeat (3) tick();
    chk("rst_db", db, 2'b00);
    chk("rst_rise", rise, 2'b00);
    chk("rst_fall", fall, 2'b00);
    chk("rst_lp", long_press, 2'b00);
    rst_n = 1'b1;
    chk("rel_db", db, 2'b00);
    watch("reset_rise", 7, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0);

    sw = 2'b10;
    watch("release", 7, 2'b11, 2'b10, 2'b00, 2'b01, 1'b0);

    pat = 5'b00111;
    for (int i = 0; i < 5; i++) begin
      sw = {1'b1, pat[i]};
      tick();
      chk("glitch_db", db, 2'b10);
      chk("glitch_rise", rise, 2'b00);
    end
    sw = 2'b11;
    watch("glitch_hold", 7, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);

    sw = 2'b00;
    watch("both_fall", 7, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0);
    sw = 2'b11;
    sw[0] = 1'b1;
    sw[1] = 1'b1;
    sw = 2'b11;
    sw[1] = 1'b1;
    sw[0] = 1'b1;
    sw = {1'b1, 1'b1};
    watch("indep", 7, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1);
    sw = 2'b01;
    repeat (10) tick();
    chk("indep_settle_db", db, 2'b01);

    sw = 2'b11;
    repeat (3) tick();
    #5;
    rst_n = 1'b0;
    #1;
    chk("midrst_db", db, 2'b00);
    chk("midrst_rise", rise, 2'b00);
    chk("midrst_fall", fall, 2'b00);
    chk("midrst_lp", long_press, 2'b00);
    repeat (2) tick();
    rst_n = 1'b1;
    watch("midrst_rise", 7, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0);

    for (int e = 2; e <= 12; e++) begin
      tick();
`ifdef DEBNC_LONGPRESS_EN
      lp_exp = (e == 8) ? 2'b11 : 2'b00;
`else
      lp_exp = 2'b00;
`endif
      chk($sformatf("long_press_e%0d", e), long_press, lp_exp);
    end
    chk("long_db", db, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debnc_multi.md
Name: debnc_multi

Overview:
Parametrised N-channel switch debouncer with edge detection; successor to the single-channel debounce detector.
Each channel synchronises a raw mechanical input, filters bounce with a per-channel stability counter, and drives a clean level plus one-cycle rise/fall strobes.
Sits between board-level switch/button pins and control logic (FSMs, counters, registers) in the same clock domain.

Parameters:
N_CH, 4, number of independent switch channels (1..32)
STABLE_CNT, 100000, consecutive synchronised-stable cycles required to accept a new level (2 ms at 50 MHz; min 2)
LONG_CNT, 50000000, cycles db must stay high before long_press strobe (used only with DEBNC_LONGPRESS_EN; min 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
sw  input  N_CH  raw asynchronous switch inputs, active-high
db  output  N_CH  debounced level per channel
rise  output  N_CH  one-cycle strobe when db goes 0->1
fall  output  N_CH  one-cycle strobe when db goes 1->0
long_press  output  N_CH  one-cycle strobe after db held high LONG_CNT cycles (0 when feature compiled out)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. Assertion clears all state immediately. Deassertion is used synchronously.
- Reset values: db=0, rise=0, fall=0, long_press=0, sync FFs=0, state=LO, counters=0.
- Per channel: 2-FF synchroniser sw -> s (2-cycle latency). No logic on the first FF output.
- FSM per channel, 4 states: LO, WAIT_HI, HI, WAIT_LO.
  - LO: s=1 -> WAIT_HI with cnt<=0.
  - WAIT_HI: s=0 -> LO (glitch rejected, no strobe). Else if cnt==STABLE_CNT-1 -> HI, db<=1, rise<=1 for one cycle. Else cnt++.
  - HI: s=0 -> WAIT_LO with cnt<=0.
  - WAIT_LO: mirror of WAIT_HI. s=1 -> HI. On terminal count -> LO, db<=0, fall<=1 for one cycle.
- Latency: sw held steady from rising edge k (first edge sampling the new level) -> db/strobe update at edge k+STABLE_CNT+2, i.e. STABLE_CNT+3 edges inclusive.
  - Any opposite sample during WAIT restarts the qualification from scratch.
- db is registered and changes only on a WAIT terminal count. db=rise/fall transitions are aligned: strobe high in the same cycle db first shows its new value.
- Counter width: $clog2(STABLE_CNT). cnt never exceeds STABLE_CNT-1; no wrap.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- Bounce shorter than STABLE_CNT cycles: db unchanged, no strobes.
- Reset mid-qualification: state discarded, no strobe on release. If sw is high after release, a normal rise follows after full latency.
- rise and fall are never both high on the same channel in the same cycle.

Optional Feature:
DEBNC_LONGPRESS_EN defined:
- Per-channel hold counter, width $clog2(LONG_CNT). Cleared on entry to HI; increments while in HI.
- On reaching LONG_CNT-1: long_press=1 for one cycle, then the counter saturates (one strobe per press).
- Leaving HI clears the counter. A WAIT_LO that returns to HI does not clear it.
Undefined:
- No hold counter logic; long_press tied to 0; port list unchanged.

Decomposition:
- Package debnc_pkg: typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} debnc_state_t; localparam DEBNC_SYNC_STAGES=2.
- Sub-module debnc_chan: one channel (synchroniser, FSM, counters, strobes).
- Top debnc_multi: generate-loop of N_CH debnc_chan instances.

Test Plan (bench: N_CH=2, STABLE_CNT=4, LONG_CNT=8, clk period 20 ns):
- Reset: rst_n=0 with sw=2'b11, release -> all outputs 0 at release; db=2'b11 with rise=2'b11 on the 7th edge after release, one cycle only.
- Glitch: sw[0] pulses 1 for 3 cycles, 0 for 2, 1 for 3 -> db[0] stays 0, no rise. Then hold 1 -> rise[0] on the 7th edge after the last 0->1.
- Release path: from db[0]=1, drive sw[0]=0 steady -> fall[0]=1 for one cycle and db[0]=0 on the 7th edge; rise[0] stays 0.
- Independence: sw[1] toggles every cycle while sw[0] held 1 -> db[1] constant, no strobes on ch1; ch0 behaves as the single-channel case.
- Mid-op reset: assert rst_n=0 asynchronously (off-edge) during WAIT_HI -> db/strobes 0 immediately. Keep sw=1 after release -> rise after full 7-edge latency.
- DEBNC_LONGPRESS_EN: hold sw[0]=1 -> long_press[0] pulses exactly once, 8 cycles after rise[0]. Repeat without the macro -> long_press stays 0.
